// File: rtl/inst_decode_ctrl_pkg.sv
// Shared ISA opcodes and decode-FSM encodings for the decode-stage controller.
package inst_decode_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic reg_wr;
    logic alu_src;
    logic mem_rd;
    logic mem_wr;
    logic mem_to_reg;
    logic reg_dst;
  } ctrl_t;

endpackage

// File: rtl/inst_decode_ctrl_register_n.sv
// N-bit register with synchronous active-high reset and write enable.
module inst_decode_ctrl_register_n #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)      r_q <= '0;
    else if (wr_en) r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/inst_decode_ctrl.sv
// Decode-stage controller: IF/ID register, decode, branch/jump resolve,
// one-word squash after redirect, HALT, and saturating perf counters.
module inst_decode_ctrl
  import inst_decode_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_in,
  input  logic             eq_flag,
  output logic             branch,
  output logic             jmp,
  output logic [15:0]      imm16,
  output logic [25:0]      jmp_imm26,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic             id_valid,
  output logic             reg_wr,
  output logic             alu_src,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      w_instr;
  logic [5:0]       w_op;
  state_t           r_state;
  state_t           w_state_nxt;
  ctrl_t            w_ctrl;
  logic             w_br;
  logic             w_jmp;
  logic             w_halt;
  logic             w_unk;
  logic             w_valid;
  logic             r_illegal;
  logic [CNT_W-1:0] r_ret;
  logic [CNT_W-1:0] r_redir;

  inst_decode_ctrl_register_n #(.N(32)) u_ifid (
    .clk   (clk),
    .reset (reset),
    .wr_en (1'b1),
    .d     (inst_in),
    .q     (w_instr)
  );

  assign w_op    = w_instr[31:26];
  assign w_valid = (r_state == ST_RUN);

  always_comb begin
    w_ctrl = '0;
    w_br   = 1'b0;
    w_jmp  = 1'b0;
    w_halt = 1'b0;
    w_unk  = 1'b0;
    if (w_valid) begin
      unique case (w_op)
        OP_RTYPE: begin
          w_ctrl.reg_wr  = 1'b1;
          w_ctrl.reg_dst = 1'b1;
        end
        OP_J:    w_jmp = 1'b1;
        OP_BEQ:  w_br  = eq_flag;
        OP_BNE:  w_br  = ~eq_flag;
        OP_ADDI: begin
          w_ctrl.reg_wr  = 1'b1;
          w_ctrl.alu_src = 1'b1;
        end
        OP_LW: begin
          w_ctrl.reg_wr     = 1'b1;
          w_ctrl.alu_src    = 1'b1;
          w_ctrl.mem_rd     = 1'b1;
          w_ctrl.mem_to_reg = 1'b1;
        end
        OP_SW: begin
          w_ctrl.alu_src = 1'b1;
          w_ctrl.mem_wr  = 1'b1;
        end
        OP_HALT: w_halt = 1'b1;
        default: w_unk  = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (w_br || w_jmp) w_state_nxt = ST_SQUASH;
        else if (w_halt)   w_state_nxt = ST_HALTED;
      end
      ST_SQUASH: w_state_nxt = ST_RUN;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_SQUASH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_SQUASH;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_ret     <= '0;
      r_redir   <= '0;
    end else begin
      if (w_unk) r_illegal <= 1'b1;
      if (w_valid && r_ret != CNT_MAX)
        r_ret <= r_ret + CNT_ONE;
      if ((w_br || w_jmp) && r_redir != CNT_MAX)
        r_redir <= r_redir + CNT_ONE;
    end
  end

  assign branch       = w_br;
  assign jmp          = w_jmp;
  assign imm16        = w_instr[15:0];
  assign jmp_imm26    = w_instr[25:0];
  assign rs           = w_instr[25:21];
  assign rt           = w_instr[20:16];
  assign rd           = w_instr[15:11];
  assign id_valid     = w_valid;
  assign reg_wr       = w_ctrl.reg_wr;
  assign alu_src      = w_ctrl.alu_src;
  assign mem_rd       = w_ctrl.mem_rd;
  assign mem_wr       = w_ctrl.mem_wr;
  assign mem_to_reg   = w_ctrl.mem_to_reg;
  assign reg_dst      = w_ctrl.reg_dst;
  assign halted       = (r_state == ST_HALTED);
  assign illegal      = r_illegal;
  assign retired_cnt  = r_ret;
  assign redirect_cnt = r_redir;

endmodule

// File: tb/tb_inst_decode_ctrl.sv
// Directed bench for inst_decode_ctrl: reset, decode, redirect/squash,
// halt, illegal opcode and counter saturation (second instance, CNT_W=4).
module tb_inst_decode_ctrl;

  localparam logic [31:0] I_ADDI = 32'h2001_0005;
  localparam logic [31:0] I_RTYP = 32'h0022_1820;
  localparam logic [31:0] I_BEQ  = 32'h1022_0004;
  localparam logic [31:0] I_BNE  = 32'h1422_0008;
  localparam logic [31:0] I_J    = 32'h0BFF_FFFC;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;
  localparam logic [31:0] I_ILL  = 32'hE800_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_in;
  logic        eq_flag;

  logic        branch, jmp, id_valid, halted, illegal;
  logic        reg_wr, alu_src, mem_rd, mem_wr, mem_to_reg, reg_dst;
  logic [15:0] imm16;
  logic [25:0] jmp_imm26;
  logic [4:0]  rs, rt, rd;
  logic [31:0] retired_cnt, redirect_cnt;

  logic        b4, j4, v4, h4, il4;
  logic        rw4, as4, mr4, mw4, mtr4, rdst4;
  logic [15:0] imm4;
  logic [25:0] ji4;
  logic [4:0]  rs4, rt4, rd4;
  logic [3:0]  ret4, red4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_decode_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .inst_in(inst_in), .eq_flag(eq_flag),
    .branch(branch), .jmp(jmp), .imm16(imm16), .jmp_imm26(jmp_imm26),
    .rs(rs), .rt(rt), .rd(rd), .id_valid(id_valid),
    .reg_wr(reg_wr), .alu_src(alu_src), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .halted(halted), .illegal(illegal),
    .retired_cnt(retired_cnt), .redirect_cnt(redirect_cnt)
  );

  inst_decode_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .inst_in(inst_in), .eq_flag(eq_flag),
    .branch(b4), .jmp(j4), .imm16(imm4), .jmp_imm26(ji4),
    .rs(rs4), .rt(rt4), .rd(rd4), .id_valid(v4),
    .reg_wr(rw4), .alu_src(as4), .mem_rd(mr4),
    .mem_wr(mw4), .mem_to_reg(mtr4), .reg_dst(rdst4),
    .halted(h4), .illegal(il4),
    .retired_cnt(ret4), .redirect_cnt(red4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, reg_wr, alu_src, mem_rd, mem_wr, mem_to_reg, reg_dst},
        {26'd0, exp});
  endtask

  initial begin
    reset   = 1'b1;
    inst_in = 32'h0;
    eq_flag = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_ret", retired_cnt, 32'd0);
    chk("rst_red", redirect_cnt, 32'd0);
    chk("rst_halt", {30'd0, halted, illegal}, 32'd0);
    chk_ctrl("rst_ctrl", 6'b000000);
    chk("rst_brj", {30'd0, branch, jmp}, 32'd0);

    // ADDI: first cycle after reset was SQUASH, now live
    reset   = 1'b0;
    inst_in = I_ADDI;
    tick();
    chk("addi_valid", 32'(id_valid), 32'd1);
    chk_ctrl("addi_ctrl", 6'b110000);
    chk("addi_imm", 32'(imm16), 32'h5);
    chk("addi_rt", {22'd0, rs, rt}, {22'd0, 5'd0, 5'd1});
    chk("addi_ret0", retired_cnt, 32'd0);
    inst_in = I_RTYP;
    tick();
    chk("ret_1", retired_cnt, 32'd1);
    chk_ctrl("rtype_ctrl", 6'b100001);
    chk("rtype_regs", {17'd0, rs, rt, rd}, {17'd0, 5'd1, 5'd2, 5'd3});

    // BEQ taken
    inst_in = I_BEQ;
    tick();
    eq_flag = 1'b1;
    #1;
    chk("beq_br", {30'd0, branch, jmp}, 32'b10);
    chk("beq_imm", 32'(imm16), 32'h4);
    inst_in = I_ADDI;
    tick();
    chk("beq_sq_valid", 32'(id_valid), 32'd0);
    chk("beq_sq_br", 32'(branch), 32'd0);
    chk_ctrl("beq_sq_ctrl", 6'b000000);
    chk("beq_red", redirect_cnt, 32'd1);
    chk("beq_ret", retired_cnt, 32'd3);

    // BEQ not taken
    inst_in = I_BEQ;
    tick();
    eq_flag = 1'b0;
    #1;
    chk("beqn_valid", 32'(id_valid), 32'd1);
    chk("beqn_br", 32'(branch), 32'd0);
    chk("beqn_ret", retired_cnt, 32'd3);
    inst_in = I_RTYP;
    tick();
    chk("beqn_next_valid", 32'(id_valid), 32'd1);
    chk("beqn_red", redirect_cnt, 32'd1);
    chk("beqn_ret2", retired_cnt, 32'd4);

    // J
    inst_in = I_J;
    tick();
    chk("j_brj", {30'd0, branch, jmp}, 32'b01);
    chk("j_imm26", 32'(jmp_imm26), 32'h3FF_FFFC);
    inst_in = I_ADDI;
    tick();
    chk("j_sq_valid", 32'(id_valid), 32'd0);
    chk_ctrl("j_sq_ctrl", 6'b000000);
    chk("j_red", redirect_cnt, 32'd2);
    chk("j_ret", retired_cnt, 32'd6);

    // BNE, BNE with eq_flag=0: second lands in the squash slot
    inst_in = I_BNE;
    tick();
    chk("bne1_br", 32'(branch), 32'd1);
    chk("bne1_imm", 32'(imm16), 32'h8);
    inst_in = I_BNE;
    tick();
    chk("bne2_valid", 32'(id_valid), 32'd0);
    chk("bne2_br", 32'(branch), 32'd0);
    inst_in = I_RTYP;
    tick();
    chk("bne_red", redirect_cnt, 32'd3);
    chk("bne_ret", retired_cnt, 32'd7);
    chk("bne_after_valid", 32'(id_valid), 32'd1);

    // HALT then ADDI
    inst_in = I_HALT;
    tick();
    chk("halt_id_valid", 32'(id_valid), 32'd1);
    chk("halt_pre", 32'(halted), 32'd0);
    inst_in = I_ADDI;
    tick();
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_valid", 32'(id_valid), 32'd0);
    chk("halt_ret", retired_cnt, 32'd9);
    tick();
    tick();
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_valid2", 32'(id_valid), 32'd0);
    chk_ctrl("halt_ctrl", 6'b000000);
    chk("halt_ret_frz", retired_cnt, 32'd9);
    chk("halt_red_frz", redirect_cnt, 32'd3);

    // Reset pulse mid-halt
    reset = 1'b1;
    tick();
    chk("rp_halt", 32'(halted), 32'd0);
    chk("rp_valid", 32'(id_valid), 32'd0);
    chk("rp_ret", retired_cnt, 32'd0);
    chk("rp_red", redirect_cnt, 32'd0);

    // Illegal opcode 0x3A
    reset   = 1'b0;
    inst_in = I_ILL;
    tick();
    chk("ill_valid", 32'(id_valid), 32'd1);
    chk_ctrl("ill_ctrl", 6'b000000);
    chk("ill_brj", {30'd0, branch, jmp}, 32'd0);
    chk("ill_pre", 32'(illegal), 32'd0);
    inst_in = I_ADDI;
    tick();
    chk("ill_set", 32'(illegal), 32'd1);
    chk("ill_ret", retired_cnt, 32'd1);
    chk("ill_halt", 32'(halted), 32'd0);

    // Drive to 20 retires: 32-bit keeps counting, 4-bit saturates
    for (int i = 0; i < 19; i++) tick();
    chk("cnt32_20", retired_cnt, 32'd20);
    chk("cnt4_sat", 32'(ret4), 32'hF);
    chk("ill_sticky", 32'(illegal), 32'd1);
    chk("cnt4_red", 32'(red4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
